// File: rtl/simd_smul_pkg.sv
// Shared definitions for the SIMD signed multiplier: mode encodings, lane geometry
// and the per-lane saturate/overflow helper.
package smul_pkg;

  typedef enum logic [1:0] {
    MODE_INT8  = 2'd0,
    MODE_INT16 = 2'd1,
    MODE_INT32 = 2'd2,
    MODE_RSVD  = 2'd3
  } mode_e;

  localparam int SLICE_W         = 32;
  localparam int SLICE_LANES_MAX = SLICE_W / 8;

  function automatic int lane_width(input logic [1:0] mode);
    case (mode)
      MODE_INT8:  return 8;
      MODE_INT16: return 16;
      MODE_INT32: return 32;
      default:    return 0;
    endcase
  endfunction

  function automatic int lane_count(input int data_w, input logic [1:0] mode);
    int lw;
    lw = lane_width(mode);
    if (lw == 0) begin
      return 0;
    end else begin
      return data_w / lw;
    end
  endfunction

  // Returns {overflow, lane_result}; only the low l bits of lane_result are meaningful.
  function automatic logic [32:0] sat_lane(input logic signed [63:0] p, input int l,
                                           input logic sat);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    logic               o;
    logic [31:0]        r;
    hi = (64'sd1 <<< (l - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (l - 1));
    o  = (p > hi) || (p < lo);
    if (sat && (p > hi)) begin
      r = hi[31:0];
    end else if (sat && (p < lo)) begin
      r = lo[31:0];
    end else begin
      r = p[31:0];
    end
    return {o, r};
  endfunction

endpackage

// File: rtl/simd_smul_slice.sv
// Combinational 32-bit multiplier slice: 4x8, 2x16 or 1x32 signed products with
// optional saturation and per-lane overflow flags (lane i in ovf[i]).
module simd_smul_slice
  import smul_pkg::*;
#(
  parameter bit SATURATE = 1'b1
) (
  input  logic [31:0] a,
  input  logic [31:0] w,
  input  logic [1:0]  mode,
  output logic [31:0] res,
  output logic [3:0]  ovf,
  output logic        illegal
);

  logic signed [63:0] p_s;
  logic [32:0]        t_s;

  // Lane-wise multiply and clamp for the selected precision.
  always_comb begin
    res     = 32'd0;
    ovf     = 4'd0;
    illegal = 1'b0;
    p_s     = 64'sd0;
    t_s     = 33'd0;
    case (mode)
      MODE_INT8: begin
        for (int i = 0; i < 4; i++) begin
          p_s = 64'($signed(a[8*i +: 8])) * 64'($signed(w[8*i +: 8]));
          t_s = sat_lane(p_s, 8, SATURATE);
          res[8*i +: 8] = t_s[7:0];
          ovf[i]        = t_s[32];
        end
      end
      MODE_INT16: begin
        for (int i = 0; i < 2; i++) begin
          p_s = 64'($signed(a[16*i +: 16])) * 64'($signed(w[16*i +: 16]));
          t_s = sat_lane(p_s, 16, SATURATE);
          res[16*i +: 16] = t_s[15:0];
          ovf[i]          = t_s[32];
        end
      end
      MODE_INT32: begin
        p_s    = 64'($signed(a)) * 64'($signed(w));
        t_s    = sat_lane(p_s, 32, SATURATE);
        res    = t_s[31:0];
        ovf[0] = t_s[32];
      end
      MODE_RSVD: begin
        illegal = 1'b1;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/simd_smul.sv
// Pipelined SIMD signed multiplier: per-beat INT8/16/32 mode, valid/ready handshake,
// lane overflow flags, sticky overflow status and delivered-beat counter.
module simd_smul
  import smul_pkg::*;
#(
  parameter int DATA_W   = 64,
  parameter int STAGES   = 3,
  parameter bit SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                sclr,
  input  logic                ce,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          in_mode,
  input  logic [DATA_W-1:0]   input_data,
  input  logic [DATA_W-1:0]   weight,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   res_mac_next,
  output logic [DATA_W/8-1:0] lane_ovf,
  output logic                out_illegal,
  input  logic                clr_status,
  output logic                ovf_sticky,
  output logic [31:0]         beat_cnt
);

  localparam int NSLICE = DATA_W / SLICE_W;
  localparam int OVF_W  = lane_count(DATA_W, MODE_INT8);

  logic              advance_s;
  logic              deliver_s;
  logic [STAGES-1:0] valid_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] w_r;
  logic [1:0]        mode_r;

  logic [DATA_W-1:0]          slice_res_s;
  logic [SLICE_LANES_MAX*NSLICE-1:0] slice_ovf_s;
  logic [NSLICE-1:0]          slice_ill_s;
  logic [OVF_W-1:0]           ovf_map_s;
  logic                       illegal_s;

  logic [DATA_W-1:0] res_pipe_r [1:STAGES-1];
  logic [OVF_W-1:0]  ovf_pipe_r [1:STAGES-1];
  logic              ill_pipe_r [1:STAGES-1];
  logic              ovf_sticky_r;
  logic [31:0]       beat_cnt_r;

  assign advance_s = ce & (~valid_r[STAGES-1] | out_ready);
  assign deliver_s = ce & valid_r[STAGES-1] & out_ready;
  assign in_ready  = advance_s & ~sclr;

  for (genvar g = 0; g < NSLICE; g++) begin : g_slice
    simd_smul_slice #(.SATURATE(SATURATE)) u_slice (
      .a       (a_r[SLICE_W*g +: SLICE_W]),
      .w       (w_r[SLICE_W*g +: SLICE_W]),
      .mode    (mode_r),
      .res     (slice_res_s[SLICE_W*g +: SLICE_W]),
      .ovf     (slice_ovf_s[SLICE_LANES_MAX*g +: SLICE_LANES_MAX]),
      .illegal (slice_ill_s[g])
    );
  end

  assign illegal_s = |slice_ill_s;

  // Re-index slice-local overflow bits onto beat-wide lane numbers for the mode.
  always_comb begin
    ovf_map_s = '0;
    case (mode_r)
      MODE_INT8: begin
        ovf_map_s = slice_ovf_s;
      end
      MODE_INT16: begin
        for (int j = 0; j < NSLICE; j++) begin
          for (int k = 0; k < 2; k++) begin
            ovf_map_s[2*j + k] = slice_ovf_s[4*j + k];
          end
        end
      end
      MODE_INT32: begin
        for (int j = 0; j < NSLICE; j++) begin
          ovf_map_s[j] = slice_ovf_s[4*j];
        end
      end
      default: begin
        ovf_map_s = '0;
      end
    endcase
  end

  // Pipeline registers: operands/mode in stage 0, product and flags shifted behind it.
  always_ff @(posedge clk) begin
    if (sclr) begin
      valid_r <= '0;
      a_r     <= '0;
      w_r     <= '0;
      mode_r  <= MODE_INT8;
      for (int k = 1; k < STAGES; k++) begin
        res_pipe_r[k] <= '0;
        ovf_pipe_r[k] <= '0;
        ill_pipe_r[k] <= 1'b0;
      end
    end else if (advance_s) begin
      valid_r <= {valid_r[STAGES-2:0], in_valid};
      // Bubbles carry zero operands so idle stages never hold stale flags.
      a_r     <= in_valid ? input_data : '0;
      w_r     <= in_valid ? weight : '0;
      mode_r  <= in_valid ? in_mode : MODE_INT8;
      res_pipe_r[1] <= slice_res_s;
      ovf_pipe_r[1] <= ovf_map_s;
      ill_pipe_r[1] <= illegal_s;
      for (int k = 2; k < STAGES; k++) begin
        res_pipe_r[k] <= res_pipe_r[k-1];
        ovf_pipe_r[k] <= ovf_pipe_r[k-1];
        ill_pipe_r[k] <= ill_pipe_r[k-1];
      end
    end
  end

  // Sticky overflow (set beats clear) and delivered-beat counter.
  always_ff @(posedge clk) begin
    if (sclr) begin
      ovf_sticky_r <= 1'b0;
      beat_cnt_r   <= 32'd0;
    end else begin
      if (deliver_s) begin
        beat_cnt_r <= beat_cnt_r + 32'd1;
      end
      if (deliver_s && (|ovf_pipe_r[STAGES-1])) begin
        ovf_sticky_r <= 1'b1;
      end else if (clr_status) begin
        ovf_sticky_r <= 1'b0;
      end
    end
  end

  assign out_valid    = valid_r[STAGES-1];
  assign res_mac_next = res_pipe_r[STAGES-1];
  assign lane_ovf     = ovf_pipe_r[STAGES-1];
  assign out_illegal  = ill_pipe_r[STAGES-1];
  assign ovf_sticky   = ovf_sticky_r;
  assign beat_cnt     = beat_cnt_r;

endmodule
